// File: rtl/mdu_hilo.sv
// mdu_hilo: multi-cycle multiply/divide unit with architectural HI/LO registers.
// An accepted mult/div holds busy for a fixed number of cycles. The 64-bit
// result is then committed to HI/LO in one step, and done pulses for one cycle.
// mthi/mtlo write a single register immediately when the unit is idle.
module mdu_hilo #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    localparam logic [4:0] MULT_LIMIT = 5'(MULT_CYCLES);
    localparam logic [4:0] DIV_LIMIT  = 5'(DIV_CYCLES);

    state_t      state_r, state_s;
    logic [4:0]  count_r, count_s;
    logic        issue_s, commit_s, mthi_s, mtlo_s;
    logic [1:0]  op_r;
    logic [31:0] a_r, b_r;
    logic        busy_r, done_r;
    logic [31:0] hi_r, lo_r;

    logic        signed_s, a_neg_s, b_neg_s;
    logic [63:0] a_ext_s, b_ext_s, prod_s, result_s;
    logic [31:0] a_mag_s, b_mag_s, divisor_s, q_mag_s, r_mag_s, quot_s, rem_s;

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

    // Next-state logic: accept issues only in IDLE and count down the fixed latency.
    always_comb begin
        state_s  = state_r;
        count_s  = count_r;
        issue_s  = 1'b0;
        commit_s = 1'b0;
        mthi_s   = 1'b0;
        mtlo_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        3'b000, 3'b001: begin
                            state_s = ST_MUL;
                            count_s = 5'd1;
                            issue_s = 1'b1;
                        end
                        3'b010, 3'b011: begin
                            state_s = ST_DIV;
                            count_s = 5'd1;
                            issue_s = 1'b1;
                        end
                        3'b100:  mthi_s  = 1'b1;
                        3'b101:  mtlo_s  = 1'b1;
                        default: state_s = ST_IDLE;
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (count_r == MULT_LIMIT) begin
                    state_s  = ST_IDLE;
                    count_s  = 5'd0;
                    commit_s = 1'b1;
                end else begin
                    count_s = count_r + 5'd1;
                end
            end
            ST_DIV: begin
                if (count_r == DIV_LIMIT) begin
                    state_s  = ST_IDLE;
                    count_s  = 5'd0;
                    commit_s = 1'b1;
                end else begin
                    count_s = count_r + 5'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                count_s = 5'd0;
            end
        endcase
    end

    // Result datapath: operate on the latched operands; divide uses sign/magnitude.
    always_comb begin
        signed_s  = ~op_r[0];
        a_ext_s   = {{32{signed_s & a_r[31]}}, a_r};
        b_ext_s   = {{32{signed_s & b_r[31]}}, b_r};
        prod_s    = a_ext_s * b_ext_s;
        a_neg_s   = signed_s & a_r[31];
        b_neg_s   = signed_s & b_r[31];
        a_mag_s   = a_neg_s ? (32'd0 - a_r) : a_r;
        b_mag_s   = b_neg_s ? (32'd0 - b_r) : b_r;
        // Divisor of zero is replaced so the divider never sees x; result is overridden below.
        divisor_s = (b_r == 32'd0) ? 32'd1 : b_mag_s;
        q_mag_s   = a_mag_s / divisor_s;
        r_mag_s   = a_mag_s % divisor_s;
        quot_s    = (a_neg_s ^ b_neg_s) ? (32'd0 - q_mag_s) : q_mag_s;
        rem_s     = a_neg_s ? (32'd0 - r_mag_s) : r_mag_s;
        if (op_r[1] == 1'b0) begin
            result_s = prod_s;
        end else if (b_r == 32'd0) begin
            result_s = {a_r, 32'hFFFF_FFFF};
        end else begin
            result_s = {rem_s, quot_s};
        end
    end

    // FSM state and latency counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            count_r <= 5'd0;
        end else begin
            state_r <= state_s;
            count_r <= count_s;
        end
    end

    // Operand latch: captured only at issue so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_r <= 2'd0;
            a_r  <= 32'd0;
            b_r  <= 32'd0;
        end else if (issue_s) begin
            op_r <= op[1:0];
            a_r  <= a;
            b_r  <= b;
        end
    end

    // Status flags: busy follows the next state, done marks the commit cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_s != ST_IDLE);
            done_r <= commit_s;
        end
    end

    // HI/LO registers: full commit on mult/div completion, single writes for mthi/mtlo.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else if (commit_s) begin
            hi_r <= result_s[63:32];
            lo_r <= result_s[31:0];
        end else if (mthi_s) begin
            hi_r <= a;
        end else if (mtlo_s) begin
            lo_r <= a;
        end
    end

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo with a high-level arithmetic reference model.
module tb_mdu_hilo;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] hi_m, lo_m;

    mdu_hilo #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: returns {hi,lo} straight from the arithmetic rules.
    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        int          ix, iy, qi, ri;
        longint      sx, sy, sp;
        logic [63:0] ux, uy;
        logic [31:0] q, r;
        ix = x;
        iy = y;
        case (o)
            3'b000: begin
                sx = ix; sy = iy; sp = sx * sy;
                return 64'(sp);
            end
            3'b001: begin
                ux = {32'd0, x}; uy = {32'd0, y};
                return ux * uy;
            end
            3'b010: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                qi = ix / iy; ri = ix % iy;
                q = qi; r = ri;
                return {r, q};
            end
            3'b011: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                q = x / y; r = x % y;
                return {r, q};
            end
            default: return 64'd0;
        endcase
    endfunction

    // Issues one mult/div and observes it; optionally noises the inputs while busy.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input bit noise,
                          output int bcnt, output int dcnt, output bit bad,
                          output logic [31:0] ho, output logic [31:0] lo_o);
        bcnt = 0; dcnt = 0; bad = 1'b0; ho = 32'd0; lo_o = 32'd0;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
        for (int c = 0; c < 64; c++) begin
            if (busy) bcnt++;
            if (busy && done) bad = 1'b1;
            if (!done && (hi !== hi_m || lo !== lo_m)) bad = 1'b1;
            if (done) begin
                dcnt++; ho = hi; lo_o = lo; start = 1'b0;
                @(negedge clk);
                if (done) dcnt++;
                if (busy) bcnt++;
                break;
            end
            if (noise) begin
                start = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                op    = (c == 0) ? 3'b000 : 3'($urandom);
                a = $urandom; b = $urandom;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b1; op = 3'b100; a = 32'hDEAD_BEEF; b = 32'd0;
        repeat (2) @(negedge clk);
        start = 1'b0;
        n_total++; if (hi !== 32'd0)  $display("FAIL reset_hi: got %h expected 0", hi);  else n_pass++;
        n_total++; if (lo !== 32'd0)  $display("FAIL reset_lo: got %h expected 0", lo);  else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
        reset = 1'b1; hi_m = 32'd0; lo_m = 32'd0;
    endtask

    task automatic test_mult();
        logic [2:0] o; logic [31:0] x, y, ho, lo_o; logic [63:0] exp;
        int bc, dc; bit bad;
        for (int i = 0; i < 10; i++) begin
            if (i == 0)      begin o = 3'b001; x = 32'hFFFF_FFFF; y = 32'd2; end
            else if (i == 1) begin o = 3'b000; x = 32'hFFFF_FFFD; y = 32'd7; end
            else             begin o = 3'($urandom_range(0, 1)); x = $urandom; y = $urandom; end
            exp = ref_result(o, x, y);
            run_op(o, x, y, i >= 6, bc, dc, bad, ho, lo_o);
            n_total++; if (bc !== MC)   $display("FAIL mult_busy_cycles[%0d]: got %0d expected %0d", i, bc, MC); else n_pass++;
            n_total++; if (dc !== 1)    $display("FAIL mult_done_pulses[%0d]: got %0d expected 1", i, dc); else n_pass++;
            n_total++; if (bad !== 1'b0) $display("FAIL mult_hold_or_overlap[%0d]: got %b expected 0", i, bad); else n_pass++;
            n_total++; if ({ho, lo_o} !== exp) $display("FAIL mult_result[%0d] op=%0d a=%h b=%h: got %h expected %h", i, o, x, y, {ho, lo_o}, exp); else n_pass++;
            hi_m = exp[63:32]; lo_m = exp[31:0];
        end
    endtask

    task automatic test_div();
        logic [2:0] o; logic [31:0] x, y, ho, lo_o; logic [63:0] exp;
        int bc, dc; bit bad;
        for (int i = 0; i < 12; i++) begin
            case (i)
                0: begin o = 3'b010; x = 32'hFFFF_FFF9; y = 32'd2; end
                1: begin o = 3'b011; x = 32'd5;         y = 32'd0; end
                2: begin o = 3'b010; x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                3: begin o = 3'b010; x = $urandom;      y = 32'd0; end
                default: begin
                    o = 3'($urandom_range(2, 3)); x = $urandom;
                    y = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 9)) : $urandom;
                    if ($urandom_range(0, 1) == 1) y = 32'd0 - y;
                end
            endcase
            exp = ref_result(o, x, y);
            run_op(o, x, y, i >= 8, bc, dc, bad, ho, lo_o);
            n_total++; if (bc !== DC)   $display("FAIL div_busy_cycles[%0d]: got %0d expected %0d", i, bc, DC); else n_pass++;
            n_total++; if (dc !== 1)    $display("FAIL div_done_pulses[%0d]: got %0d expected 1", i, dc); else n_pass++;
            n_total++; if (bad !== 1'b0) $display("FAIL div_hold_or_overlap[%0d]: got %b expected 0", i, bad); else n_pass++;
            n_total++; if ({ho, lo_o} !== exp) $display("FAIL div_result[%0d] op=%0d a=%h b=%h: got %h expected %h", i, o, x, y, {ho, lo_o}, exp); else n_pass++;
            hi_m = exp[63:32]; lo_m = exp[31:0];
        end
    endtask

    task automatic test_ignore_abort();
        logic [31:0] ho, lo_o; int bc, dc, dpulse, bsamp; bit bad;
        run_op(3'b011, 32'd9, 32'd4, 1'b1, bc, dc, bad, ho, lo_o);
        n_total++; if (bc !== DC)    $display("FAIL ignore_busy_cycles: got %0d expected %0d", bc, DC); else n_pass++;
        n_total++; if (dc !== 1)     $display("FAIL ignore_done_pulses: got %0d expected 1", dc); else n_pass++;
        n_total++; if (bad !== 1'b0) $display("FAIL ignore_hold: got %b expected 0", bad); else n_pass++;
        n_total++; if (ho !== 32'd1) $display("FAIL ignore_hi: got %h expected 1", ho); else n_pass++;
        n_total++; if (lo_o !== 32'd2) $display("FAIL ignore_lo: got %h expected 2", lo_o); else n_pass++;
        hi_m = 32'd1; lo_m = 32'd2;
        @(negedge clk);
        start = 1'b1; op = 3'b010; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        n_total++; if (busy !== 1'b1) $display("FAIL abort_busy_before: got %b expected 1", busy); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_total++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL abort_done: got %b expected 0", done); else n_pass++;
        n_total++; if (hi !== 32'd0)  $display("FAIL abort_hi: got %h expected 0", hi); else n_pass++;
        n_total++; if (lo !== 32'd0)  $display("FAIL abort_lo: got %h expected 0", lo); else n_pass++;
        reset = 1'b1; hi_m = 32'd0; lo_m = 32'd0;
        dpulse = 0; bsamp = 0;
        for (int c = 0; c < DC + 4; c++) begin
            @(negedge clk);
            if (done) dpulse++;
            if (busy) bsamp++;
        end
        n_total++; if (dpulse !== 0) $display("FAIL abort_no_commit_done: got %0d expected 0", dpulse); else n_pass++;
        n_total++; if (bsamp !== 0)  $display("FAIL abort_no_busy: got %0d expected 0", bsamp); else n_pass++;
        n_total++; if ({hi, lo} !== 64'd0) $display("FAIL abort_no_commit_hilo: got %h expected 0", {hi, lo}); else n_pass++;
    endtask

    task automatic test_mthi_mtlo();
        logic [31:0] r;
        @(negedge clk);
        start = 1'b1; op = 3'b100; a = 32'h0000_1234;
        @(negedge clk);
        n_total++; if (hi !== 32'h1234) $display("FAIL mthi_hi: got %h expected 00001234", hi); else n_pass++;
        n_total++; if (lo !== lo_m)     $display("FAIL mthi_lo_kept: got %h expected %h", lo, lo_m); else n_pass++;
        n_total++; if (busy !== 1'b0)   $display("FAIL mthi_busy: got %b expected 0", busy); else n_pass++;
        op = 3'b101; a = 32'h0000_5678;
        @(negedge clk);
        n_total++; if (lo !== 32'h5678) $display("FAIL mtlo_lo: got %h expected 00005678", lo); else n_pass++;
        n_total++; if (hi !== 32'h1234) $display("FAIL mtlo_hi_kept: got %h expected 00001234", hi); else n_pass++;
        n_total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL mtlo_flags: got busy=%b done=%b expected 0 0", busy, done); else n_pass++;
        hi_m = 32'h1234; lo_m = 32'h5678;
        for (int i = 0; i < 4; i++) begin
            r = $urandom;
            op = 3'($urandom_range(6, 7)); a = r; b = $urandom;
            @(negedge clk);
            n_total++; if ({hi, lo, busy, done} !== {hi_m, lo_m, 2'b00}) $display("FAIL reserved_op[%0d]: got hi=%h lo=%h busy=%b done=%b expected %h %h 0 0", i, hi, lo, busy, done, hi_m, lo_m); else n_pass++;
        end
        start = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] x1, y1, x2, y2; logic [63:0] e1, e2; int bc; bit got;
        x1 = $urandom; y1 = $urandom; x2 = $urandom; y2 = 32'($urandom_range(1, 1000));
        e1 = ref_result(3'b000, x1, y1);
        e2 = ref_result(3'b011, x2, y2);
        @(negedge clk);
        start = 1'b1; op = 3'b000; a = x1; b = y1;
        @(negedge clk);
        start = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done) begin got = 1'b1; break; end
            @(negedge clk);
        end
        n_total++; if (got !== 1'b1) $display("FAIL b2b_first_done: got %b expected 1", got); else n_pass++;
        n_total++; if ({hi, lo} !== e1) $display("FAIL b2b_first_result: got %h expected %h", {hi, lo}, e1); else n_pass++;
        hi_m = e1[63:32]; lo_m = e1[31:0];
        start = 1'b1; op = 3'b011; a = x2; b = y2;
        @(negedge clk);
        start = 1'b0;
        n_total++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL b2b_accept: got busy=%b done=%b expected 1 0", busy, done); else n_pass++;
        bc = 0; got = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done) begin got = 1'b1; break; end
            if (busy) bc++;
            @(negedge clk);
        end
        n_total++; if (got !== 1'b1) $display("FAIL b2b_second_done: got %b expected 1", got); else n_pass++;
        n_total++; if (bc !== DC) $display("FAIL b2b_second_busy: got %0d expected %0d", bc, DC); else n_pass++;
        n_total++; if ({hi, lo} !== e2) $display("FAIL b2b_second_result: got %h expected %h", {hi, lo}, e2); else n_pass++;
        hi_m = e2[63:32]; lo_m = e2[31:0];
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_ignore_abort();
        test_mthi_mtlo();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers, placed directly beside the single-cycle datapath.
- The datapath issues mult/multu/div/divu/mthi/mtlo and reads HI/LO for mfhi/mflo.
- `busy` tells the datapath to stall any HI/LO access until a result is committed.
- Operation latency is fixed and set by parameters.

Parameters:
- MULT_CYCLES, 5, cycles `busy` stays high for mult/multu (legal range 1..31)
- DIV_CYCLES, 10, cycles `busy` stays high for div/divu (legal range 1..31)

Ports:
- clk    input   1   system clock, rising edge
- reset  input   1   synchronous, active-low reset; sampled on the clk rising edge
- start  input   1   issue strobe; sampled each rising edge
- op     input   3   000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 11x reserved
- a      input   32  rs operand (dividend / multiplicand / mthi-mtlo source)
- b      input   32  rt operand (divisor / multiplier)
- busy   output  1   operation in flight; HI/LO not yet valid
- done   output  1   one-cycle pulse when a mult/div result commits
- hi     output  32  HI register
- lo     output  32  LO register

Behaviour:
- Reset (reset==0 at an edge): state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0. Reset overrides start.
- Reset mid-operation aborts the operation; no result commits.
- States:
  - IDLE -> MUL on start with op 000/001.
  - IDLE -> DIV on start with op 010/011.
  - MUL/DIV -> IDLE when counter reaches its limit.
- Issue at edge E0 (IDLE, start=1, mult/div op):
  - a, b and op are latched at E0.
  - busy=1 after E0, counter=1.
  - Later changes on a/b/op have no effect.
- Commit at edge E_N (N = MULT_CYCLES or DIV_CYCLES):
  - hi/lo are written.
  - busy=0, done=1 for exactly one cycle.
  - `busy` is therefore high for exactly N cycles.
- Back-to-back issue: start is accepted again at E_N+1 or later.
- start while busy: ignored entirely; no queueing, no error, operands discarded.
- mthi/mtlo in IDLE:
  - hi (or lo) <= a at the same edge.
  - busy is never asserted and done is not pulsed.
  - The other register is unchanged.
- Reserved op with start: ignored.
- Multiply result is a 64-bit product, {hi,lo} = product.
  - mult: signed two's-complement.
  - multu: unsigned.
  - Computed from the latched operands; only the final value is visible at commit.
- Divide results: lo = quotient, hi = remainder.
  - div: signed; quotient truncated toward zero; remainder takes the sign of the dividend.
  - divu: unsigned.
- Divide boundary cases:
  - b==0 (div or divu): lo=32'hFFFFFFFF, hi=a. Full latency still applies.
  - div 32'h80000000 / 32'hFFFFFFFF: lo=32'h80000000, hi=0.
- hi/lo hold their previous values throughout busy; the outputs never show intermediate values.
- done and busy are never both 1.

Test Plan:
- Reset, then hold reset=0 for 2 cycles -> hi=0, lo=0, busy=0, done=0.
- multu a=32'hFFFFFFFF b=32'h2, issue at E0 -> busy high for 5 cycles; at E5 hi=1, lo=32'hFFFFFFFE, done pulse for 1 cycle.
- mult a=-3 b=7 -> {hi,lo}=64'hFFFFFFFF_FFFFFFEB after 5 cycles.
- div a=-7 b=2 -> after 10 cycles lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1).
- divu a=5 b=0 -> lo=32'hFFFFFFFF, hi=5.
- div 32'h80000000 / -1 -> lo=32'h80000000, hi=0.
- Start divu a=9 b=4; pulse start with mult during busy; assert reset=0 at cycle 3 of a second div -> first: lo=2, hi=1, mult ignored; second: aborted, hi=lo=0, busy=0 next cycle.
- mthi a=32'h1234 then mtlo a=32'h5678 on consecutive cycles -> hi=32'h1234, lo=32'h5678, busy never asserted.
